// File: rtl/ack_handshake_tx.sv
// rtl/ack_handshake_tx.sv - transmit endpoint of the validdata/acknowledge handshake.
// Serialises a captured word LSB first, then waits for acknowledge with timeout-driven retries.
module ack_handshake_tx #(
  parameter int WIDTH     = 8,
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             validdata,
  input  logic             acknowledge,
  input  logic [WIDTH-1:0] data_in,
  output logic             tx_bit,
  output logic             tx_en,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             overrun,
  output logic [2:0]       retry_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [TW-1:0]    tmo_cnt;
  logic             last_bit;
  logic             tmo_term;
  logic             retry_ok;

  assign last_bit = (bit_cnt == CW'(WIDTH - 1));
  assign tmo_term = (tmo_cnt == TW'(TIMEOUT - 1));
  assign retry_ok = (retry_cnt < 3'(MAX_RETRY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // acknowledge is only meaningful in S_WAIT, and it wins over the timeout terminal count
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (validdata) state_nx = S_SHIFT;
      S_SHIFT: if (last_bit) state_nx = S_WAIT;
      S_WAIT: begin
        if (acknowledge) begin
          state_nx = S_DONE;
        end else if (tmo_term) begin
          state_nx = retry_ok ? S_SHIFT : S_ERR;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    tx_en  = (state == S_SHIFT);
    tx_bit = 1'b0;
    if (state == S_SHIFT) tx_bit = shreg[bit_cnt];
    busy   = (state != S_IDLE);
    done   = (state == S_DONE);
    error  = (state == S_ERR);
  end

  // shreg is never shifted so a retry can resend the same word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      retry_cnt <= 3'd0;
      overrun   <= 1'b0;
    end else begin
      overrun <= validdata && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          bit_cnt <= '0;
          tmo_cnt <= '0;
          if (validdata) begin
            shreg     <= data_in;
            retry_cnt <= 3'd0;
          end
        end
        S_SHIFT: begin
          bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
          tmo_cnt <= '0;
        end
        S_WAIT: begin
          bit_cnt <= '0;
          tmo_cnt <= tmo_term ? '0 : tmo_cnt + 1'b1;
          if (!acknowledge && tmo_term && retry_ok) retry_cnt <= retry_cnt + 3'd1;
        end
        default: begin
          bit_cnt <= '0;
          tmo_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ack_handshake_tx.sv
// tb/tb_ack_handshake_tx.sv - bench for ack_handshake_tx.
// Expected serial bits are queued when a word is launched and popped as tx_en bits appear.
module tb_ack_handshake_tx;

  localparam int WIDTH     = 8;
  localparam int TIMEOUT   = 64;
  localparam int MAX_RETRY = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             validdata = 1'b0;
  logic             acknowledge = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             tx_bit;
  logic             tx_en;
  logic             busy;
  logic             done;
  logic             error;
  logic             overrun;
  logic [2:0]       retry_cnt;

  int   total = 0;
  int   bad = 0;
  logic exp_q[$];

  ack_handshake_tx #(
    .WIDTH(WIDTH),
    .TIMEOUT(TIMEOUT),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .validdata(validdata),
    .acknowledge(acknowledge),
    .data_in(data_in),
    .tx_bit(tx_bit),
    .tx_en(tx_en),
    .busy(busy),
    .done(done),
    .error(error),
    .overrun(overrun),
    .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  // scoreboard consumer: every transmitted bit must match the next queued bit
  always @(negedge clk) begin
    if (!rst && tx_en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_bit: got tx_bit=%0b, required no transmission", tx_bit);
      end else begin
        logic e;
        e = exp_q.pop_front();
        if (tx_bit !== e) begin
          bad++;
          $display("FAIL tx_bit: got %0b, required %0b", tx_bit, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) exp_q.push_back(w[i]);
  endtask

  // launches a one-cycle validdata; returns in the first SHIFT cycle
  task automatic send(input logic [WIDTH-1:0] w);
    validdata = 1'b1;
    data_in   = w;
    push_word(w);
    step();
    validdata = 1'b0;
    data_in   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total++;
    if ({tx_bit, tx_en, busy, done, error, overrun, retry_cnt} !== 9'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b, required 000000000",
               {tx_bit, tx_en, busy, done, error, overrun, retry_cnt});
    end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    send(8'hA5);
    total++;
    if (tx_en !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_first_bit: got tx_en=%0b busy=%0b, required 1 1", tx_en, busy);
    end
    repeat (WIDTH) step();
    total++;
    if (tx_en !== 1'b0 || tx_bit !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_wait: got tx_en=%0b tx_bit=%0b busy=%0b, required 0 0 1", tx_en, tx_bit, busy);
    end
    repeat (36) step();
    acknowledge = 1'b1;
    step();
    acknowledge = 1'b0;
    total++;
    if (done !== 1'b1 || retry_cnt !== 3'd0) begin
      bad++;
      $display("FAIL basic_done: got done=%0b retry_cnt=%0d, required 1 0", done, retry_cnt);
    end
    // validdata in the DONE cycle is dropped
    validdata = 1'b1;
    data_in   = 8'hFF;
    step();
    validdata = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b1) begin
      bad++;
      $display("FAIL done_cycle_drop: got busy=%0b done=%0b overrun=%0b, required 0 0 1", busy, done, overrun);
    end
    step();
    total++;
    if (overrun !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_cycle_idle: got overrun=%0b busy=%0b, required 0 0", overrun, busy);
    end
  endtask

  task automatic test_latency();
    int n;
    send(8'h5A);
    n = 1;
    repeat (WIDTH) begin
      step();
      n++;
    end
    acknowledge = 1'b1;
    step();
    n++;
    acknowledge = 1'b0;
    total++;
    if (done !== 1'b1 || n != WIDTH + 2) begin
      bad++;
      $display("FAIL min_latency: got done=%0b at %0d cycles, required 1 at %0d", done, n, WIDTH + 2);
    end
    step();
  endtask

  task automatic test_retry();
    send(8'hA5);
    repeat (WIDTH) step();
    push_word(8'hA5);
    repeat (TIMEOUT - 1) step();
    total++;
    if (tx_en !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL retry_terminal: got tx_en=%0b busy=%0b, required 0 1", tx_en, busy);
    end
    step();
    total++;
    if (tx_en !== 1'b1 || retry_cnt !== 3'd1) begin
      bad++;
      $display("FAIL retry_resend: got tx_en=%0b retry_cnt=%0d, required 1 1", tx_en, retry_cnt);
    end
    repeat (WIDTH + 3) step();
    acknowledge = 1'b1;
    step();
    acknowledge = 1'b0;
    total++;
    if (done !== 1'b1 || retry_cnt !== 3'd1) begin
      bad++;
      $display("FAIL retry_done: got done=%0b retry_cnt=%0d, required 1 1", done, retry_cnt);
    end
    step();
  endtask

  task automatic test_error();
    send(8'h96);
    for (int r = 0; r <= MAX_RETRY; r++) begin
      repeat (WIDTH) step();
      if (r < MAX_RETRY) push_word(8'h96);
      repeat (TIMEOUT) step();
    end
    total++;
    if (error !== 1'b1 || done !== 1'b0 || retry_cnt !== 3'(MAX_RETRY) || busy !== 1'b1) begin
      bad++;
      $display("FAIL error_pulse: got error=%0b done=%0b retry_cnt=%0d busy=%0b, required 1 0 %0d 1",
               error, done, retry_cnt, busy, MAX_RETRY);
    end
    step();
    total++;
    if (error !== 1'b0 || busy !== 1'b0 || retry_cnt !== 3'(MAX_RETRY)) begin
      bad++;
      $display("FAIL error_after: got error=%0b busy=%0b retry_cnt=%0d, required 0 0 %0d",
               error, busy, retry_cnt, MAX_RETRY);
    end
  endtask

  task automatic test_overrun();
    send(8'h3C);
    step();
    step();
    validdata   = 1'b1;
    data_in     = 8'hFF;
    acknowledge = 1'b1;
    step();
    validdata   = 1'b0;
    acknowledge = 1'b0;
    total++;
    if (overrun !== 1'b1 || tx_en !== 1'b1) begin
      bad++;
      $display("FAIL overrun_pulse: got overrun=%0b tx_en=%0b, required 1 1", overrun, tx_en);
    end
    step();
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_single: got overrun=%0b, required 0", overrun);
    end
    repeat (WIDTH - 4) step();
    repeat (5) step();
    total++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL spurious_ack: got done=%0b busy=%0b, required 0 1", done, busy);
    end
    acknowledge = 1'b1;
    step();
    acknowledge = 1'b0;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL overrun_done: got done=%0b, required 1", done);
    end
    step();
  endtask

  task automatic test_held_validdata();
    validdata = 1'b1;
    data_in   = 8'h81;
    push_word(8'h81);
    step();
    step();
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL held_overrun1: got overrun=%0b, required 1", overrun);
    end
    step();
    validdata = 1'b0;
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL held_overrun2: got overrun=%0b, required 1", overrun);
    end
    step();
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL held_overrun_end: got overrun=%0b, required 0", overrun);
    end
    repeat (WIDTH - 3) step();
    acknowledge = 1'b1;
    step();
    acknowledge = 1'b0;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL held_done: got done=%0b, required 1", done);
    end
    step();
  endtask

  task automatic test_collision();
    send(8'hC6);
    repeat (WIDTH) step();
    repeat (TIMEOUT - 1) step();
    acknowledge = 1'b1;
    step();
    acknowledge = 1'b0;
    total++;
    if (done !== 1'b1 || tx_en !== 1'b0 || retry_cnt !== 3'd0) begin
      bad++;
      $display("FAIL collision: got done=%0b tx_en=%0b retry_cnt=%0d, required 1 0 0", done, tx_en, retry_cnt);
    end
    step();
  endtask

  task automatic test_reset_mid();
    send(8'h5A);
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    total++;
    if ({tx_bit, tx_en, busy, done, error, overrun, retry_cnt} !== 9'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got %b, required 000000000",
               {tx_bit, tx_en, busy, done, error, overrun, retry_cnt});
    end
    step();
    rst = 1'b0;
    repeat (3) step();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_idle: got busy=%0b done=%0b error=%0b, required 0 0 0", busy, done, error);
    end
    send(8'hC3);
    repeat (WIDTH) step();
    acknowledge = 1'b1;
    step();
    acknowledge = 1'b0;
    total++;
    if (done !== 1'b1 || retry_cnt !== 3'd0) begin
      bad++;
      $display("FAIL reset_mid_clean: got done=%0b retry_cnt=%0d, required 1 0", done, retry_cnt);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_retry();
    test_error();
    test_overrun();
    test_held_validdata();
    test_collision();
    test_reset_mid();
    repeat (2) step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL bits_outstanding: got %0d unsent bits, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
